s4ga_cfg_seq: RTL and testbench

- Configuration sequencer for the s4ga LUT fabric.
- Holds one packed config word per LUT in an internal N-entry store, loaded by a host write port.
- Streams the store to the fabric as SI_W-bit segments, one segment per enabled fabric clock.
- Owns fabric reset sequencing, plus run / stop / single-sweep-step control, so the fabric's LUT/input/segment counters stay frame-aligned.

---
 rtl/s4ga_cfg_seq.sv | 178 +++++++++++++++++
 tb/tb_s4ga_cfg_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/s4ga_cfg_seq.sv
// s4ga_cfg_seq: configuration sequencer for the s4ga LUT fabric.
// Streams a host-loaded config store to the fabric and sequences its reset.
module s4ga_cfg_seq #(
    parameter  int N        = 128,
    parameter  int K        = 4,
    parameter  int SI_W     = 4,
    parameter  int SWEEP_W  = 16,
    localparam int N_W       = $clog2(N),
    localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W,
    localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W,
    localparam int SEGS      = K * IDX_SEGS + MASK_SEGS,
    localparam int CFG_W     = SEGS * SI_W,
    localparam int RST_CYC   = N + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [N_W-1:0]     wr_addr,
    input  logic [CFG_W-1:0]   wr_data,
    output logic [SI_W-1:0]    fab_si,
    output logic               fab_rst,
    output logic               fab_ce,
    output logic [1:0]         state,
    output logic [N_W-1:0]     lut_idx,
    output logic               sweep_done,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int RC_W  = $clog2(RST_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } st_t;

    st_t              st;
    logic [SEG_W-1:0] seg;
    logic [RC_W-1:0]  rst_cnt;
    logic             stop_pend;
    logic             step_mode;

    logic [CFG_W-1:0] mem [N];

    logic             last_seg;
    logic             at_end;
    logic [SEG_W-1:0] nxt_seg;
    logic [N_W-1:0]   nxt_idx;
    logic [SI_W-1:0]  nxt_si;
    logic             nxt_last;
    logic [SI_W-1:0]  first_si;
    logic             first_last;

    assign state = st;

    function automatic logic [SI_W-1:0] seg_of(
        input logic [CFG_W-1:0] w,
        input int               s
    );
        return w[CFG_W-1-s*SI_W -: SI_W];
    endfunction

    // Config store: no reset so contents survive rst; host writes only when ready.
    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready)
            mem[wr_addr] <= wr_data;
    end

    // Next stream position and the segment it will present.
    always_comb begin
        last_seg   = (seg == SEG_W'(SEGS - 1));
        at_end     = last_seg && (lut_idx == N_W'(N - 1));
        nxt_seg    = last_seg ? '0 : seg + 1'b1;
        nxt_idx    = lut_idx;
        if (last_seg)
            nxt_idx = (lut_idx == N_W'(N - 1)) ? '0 : lut_idx + 1'b1;
        nxt_si     = seg_of(mem[nxt_idx], int'(nxt_seg));
        nxt_last   = (nxt_seg == SEG_W'(SEGS - 1)) && (nxt_idx == N_W'(N - 1));
        first_si   = seg_of(mem[0], 0);
        first_last = (SEGS == 1) && (N == 1);
    end

    // Sequencer FSM with registered fabric and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            fab_rst    <= 1'b0;
            fab_ce     <= 1'b0;
            fab_si     <= '0;
            lut_idx    <= '0;
            seg        <= '0;
            sweep_done <= 1'b0;
            sweep_cnt  <= '0;
            rst_cnt    <= '0;
            stop_pend  <= 1'b0;
            step_mode  <= 1'b0;
            wr_ready   <= 1'b1;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (start) begin
                        st        <= S_RESET;
                        fab_rst   <= 1'b1;
                        fab_ce    <= 1'b1;
                        fab_si    <= '0;
                        rst_cnt   <= '0;
                        sweep_cnt <= '0;
                        stop_pend <= 1'b0;
                        step_mode <= 1'b0;
                        wr_ready  <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                        st         <= S_RUN;
                        fab_rst    <= 1'b0;
                        fab_si     <= first_si;
                        lut_idx    <= '0;
                        seg        <= '0;
                        sweep_done <= first_last;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (at_end)
                        sweep_cnt <= sweep_cnt + 1'b1;
                    if (at_end && (stop_pend || step_mode || stop)) begin
                        st         <= S_HALT;
                        fab_ce     <= 1'b0;
                        lut_idx    <= '0;
                        seg        <= '0;
                        sweep_done <= 1'b0;
                        stop_pend  <= 1'b0;
                        step_mode  <= 1'b0;
                        wr_ready   <= 1'b1;
                    end else begin
                        fab_si     <= nxt_si;
                        lut_idx    <= nxt_idx;
                        seg        <= nxt_seg;
                        sweep_done <= nxt_last;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        st        <= S_RESET;
                        fab_rst   <= 1'b1;
                        fab_ce    <= 1'b1;
                        fab_si    <= '0;
                        rst_cnt   <= '0;
                        sweep_cnt <= '0;
                        stop_pend <= 1'b0;
                        step_mode <= 1'b0;
                        wr_ready  <= 1'b0;
                    end else if (step) begin
                        st         <= S_RUN;
                        step_mode  <= 1'b1;
                        fab_ce     <= 1'b1;
                        fab_si     <= first_si;
                        lut_idx    <= '0;
                        seg        <= '0;
                        sweep_done <= first_last;
                        wr_ready   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s4ga_cfg_seq.sv
// tb_s4ga_cfg_seq: directed bench for the s4ga config sequencer.
// Small fabric (N=4, K=2, SI_W=4): 3 segments per LUT, 12 per sweep.
module tb_s4ga_cfg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        step;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  fab_si;
    logic        fab_rst;
    logic        fab_ce;
    logic [1:0]  state;
    logic [1:0]  lut_idx;
    logic        sweep_done;
    logic [15:0] sweep_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [47:0] S1 = 48'h12A_238_306_01F;
    localparam logic [47:0] S2 = 48'h12A_238_10C_01F;

    s4ga_cfg_seq #(.N(4), .K(2), .SI_W(4), .SWEEP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fab_si     (fab_si),
        .fab_rst    (fab_rst),
        .fab_ce     (fab_ce),
        .state      (state),
        .lut_idx    (lut_idx),
        .sweep_done (sweep_done),
        .sweep_cnt  (sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [11:0] d);
        chk("wr_ready", 32'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic chk_reset_phase();
        for (int i = 0; i < 6; i++) begin
            chk("rst_state", 32'(state), 1);
            chk("rst_fab_rst", 32'(fab_rst), 1);
            chk("rst_fab_ce", 32'(fab_ce), 1);
            chk("rst_fab_si", 32'(fab_si), 0);
            cyc();
        end
    endtask

    // kind: 0 none, 1 stop, 2 start+stop, 3 blocked host write
    task automatic sweep(input logic [47:0] e, input int at, input int kind);
        for (int j = 0; j < 12; j++) begin
            chk("si", 32'(fab_si), 32'(e[47-4*j -: 4]));
            chk("ce", 32'(fab_ce), 1);
            chk("idx", 32'(lut_idx), 32'(j / 3));
            chk("done", 32'(sweep_done), 32'(j == 11));
            if (j == 0) chk("run_state", 32'(state), 2);
            if (j == at && kind == 1) stop = 1'b1;
            if (j == at && kind == 2) begin
                stop  = 1'b1;
                start = 1'b1;
            end
            if (j == at && kind == 3) begin
                chk("busy_ready", 32'(wr_ready), 0);
                wr_valid = 1'b1;
                wr_addr  = 2'd2;
                wr_data  = 12'hFFF;
            end
            cyc();
            stop     = 1'b0;
            start    = 1'b0;
            wr_valid = 1'b0;
        end
    endtask

    task automatic chk_halt(input int cnt);
        chk("halt_state", 32'(state), 3);
        chk("halt_ce", 32'(fab_ce), 0);
        chk("halt_ready", 32'(wr_ready), 1);
        chk("halt_si", 32'(fab_si), 32'hF);
        chk("halt_idx", 32'(lut_idx), 0);
        chk("halt_cnt", 32'(sweep_cnt), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        step     = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        cyc();
        cyc();
        rst = 1'b0;

        chk("r_state", 32'(state), 0);
        chk("r_fab_rst", 32'(fab_rst), 0);
        chk("r_fab_ce", 32'(fab_ce), 0);
        chk("r_fab_si", 32'(fab_si), 0);
        chk("r_idx", 32'(lut_idx), 0);
        chk("r_done", 32'(sweep_done), 0);
        chk("r_cnt", 32'(sweep_cnt), 0);
        chk("r_ready", 32'(wr_ready), 1);

        stop = 1'b1;
        step = 1'b1;
        cyc();
        stop = 1'b0;
        step = 1'b0;
        chk("idle_ignore", 32'(state), 0);

        wr(2'd0, 12'h12A);
        wr(2'd1, 12'h238);
        wr(2'd2, 12'h306);
        wr(2'd3, 12'h01F);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_reset_phase();

        sweep(S1, -1, 0);
        chk("cnt1", 32'(sweep_cnt), 1);
        sweep(S1, 2, 3);
        chk("cnt2", 32'(sweep_cnt), 2);
        sweep(S1, 4, 1);
        chk_halt(3);

        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("halt_stop_ign", 32'(state), 3);

        wr(2'd2, 12'h10C);
        step = 1'b1;
        cyc();
        step = 1'b0;
        sweep(S2, -1, 0);
        chk_halt(4);
        cyc();
        chk("halt_stays", 32'(state), 3);

        start = 1'b1;
        step  = 1'b1;
        cyc();
        start = 1'b0;
        step  = 1'b0;
        chk("ss_cnt", 32'(sweep_cnt), 0);
        chk_reset_phase();
        sweep(S2, 5, 2);
        chk_halt(1);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_reset_phase();
        for (int j = 0; j < 6; j++) cyc();
        chk("pre_rst_si", 32'(fab_si), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_state", 32'(state), 0);
        chk("mid_ce", 32'(fab_ce), 0);
        chk("mid_idx", 32'(lut_idx), 0);
        chk("mid_cnt", 32'(sweep_cnt), 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_reset_phase();
        chk("keep_si0", 32'(fab_si), 32'h1);
        cyc();
        chk("keep_si1", 32'(fab_si), 32'h2);
        cyc();
        chk("keep_si2", 32'(fab_si), 32'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
